// File: rtl/ifetch_pkg.sv
// Shared constants for the fetch stage: widths, FSM state codes, NOP and the PC increment helper.
package ifetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0]         HALT_OPCODE_DEF = 4'hF;
  localparam logic [INSTR_W-1:0] NOP             = 16'h0000;

  // Word-addressed PC; the wrap from FFFF to 0000 is intentional.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a new instruction, flush drops only the valid bit,
// and the register otherwise holds.
import ifetch_pkg::*;

module if_id_reg (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [ADDR_W-1:0]  d_pc_plus1,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP;
      pc       <= '0;
      pc_plus1 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus1 <= d_pc_plus1;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, BOOT/RUN/HALT sequencing and redirect handling in front of the IF/ID register.
// Optional halt-on-opcode behaviour is enabled by defining IFETCH_HALT_EN.
import ifetch_pkg::*;

module instruction_fetch #(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               halted
);

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              load, flush;
  logic              halted_next;

  assign imem_addr = pc;

  // A redirect always wins over a load; a stalled register simply keeps its contents.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    load        = 1'b0;
    flush       = 1'b0;
    halted_next = halted;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          flush   = 1'b1;
        end else if (!id_valid || id_ready) begin
          load    = 1'b1;
          pc_next = pc_inc(pc);
`ifdef IFETCH_HALT_EN
          if (imem_data[15:12] == HALT_OPCODE) begin
            pc_next     = pc;
            halted_next = 1'b1;
            state_next  = ST_HALT;
          end
`endif
        end
      end
`ifdef IFETCH_HALT_EN
      ST_HALT: begin
        if (redirect_valid) begin
          pc_next     = redirect_pc;
          flush       = 1'b1;
          halted_next = 1'b0;
          state_next  = ST_RUN;
        end else if (id_ready) begin
          flush = 1'b1;
        end
      end
`endif
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

`ifdef IFETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= halted_next;
  end
`else
  assign halted = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (flush),
    .d_instr    (imem_data),
    .d_pc       (pc),
    .d_pc_plus1 (pc_inc(pc)),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc         (id_pc),
    .pc_plus1   (id_pc_plus1)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a cycle-level reference model predicts the outputs
// after every clock edge, a negedge monitor compares the DUT against the queued predictions.
module tb_instruction_fetch;

  localparam logic [15:0] RPC = 16'h0010;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc1;
    logic        halted;
    logic [15:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr, id_pc, id_pc_plus1;
  logic        halted;

  logic [15:0] mem [0:65535];
  exp_t        expq[$];
  int          tests = 0;
  int          failed = 0;

  // Reference model state: 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_valid, m_halted;
  logic [15:0] m_instr, m_id_pc, m_id_pc1;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC), .HALT_OPCODE(4'hF)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus1    (id_pc_plus1),
    .halted         (halted)
  );

  // Model: apply the behavioural rules to the inputs seen at this edge and queue the prediction.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_mode = 0; m_pc = RPC; m_valid = 1'b0; m_halted = 1'b0;
      m_instr = 16'h0000; m_id_pc = 16'h0000; m_id_pc1 = 16'h0000;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_halted = 1'b0; m_mode = 1;
    end else if (m_mode == 2) begin
      if (id_ready) m_valid = 1'b0;
    end else if (!m_valid || id_ready) begin
      m_valid = 1'b1; m_instr = mem[m_pc]; m_id_pc = m_pc; m_id_pc1 = 16'(m_pc + 1);
`ifdef IFETCH_HALT_EN
      if (m_instr[15:12] == 4'hF) begin
        m_halted = 1'b1; m_mode = 2;
      end else
`endif
      m_pc = 16'(m_pc + 1);
    end
    e = '{m_valid, m_instr, m_id_pc, m_id_pc1, m_halted, m_pc};
    expq.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    tests++;
    if (id_valid !== e.valid || imem_addr !== e.addr || halted !== e.halted ||
        (e.valid && (id_instr !== e.instr || id_pc !== e.pc || id_pc_plus1 !== e.pc1)) ||
        (!e.valid && m_mode == 0 && (id_instr !== e.instr || id_pc !== e.pc))) begin
      failed++;
      $display("[TB] FAIL cycle_check t=%0t: got valid=%b instr=%h pc=%h pc1=%h halted=%b addr=%h, want valid=%b instr=%h pc=%h pc1=%h halted=%b addr=%h",
               $time, id_valid, id_instr, id_pc, id_pc_plus1, halted, imem_addr,
               e.valid, e.instr, e.pc, e.pc1, e.halted, e.addr);
    end
  endtask

  // Monitor: one prediction per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (expq.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard_empty t=%0t: got no prediction, want one per cycle", $time);
    end else begin
      checkOutput(expq.pop_front());
    end
  end

  task automatic applyStimulus(input logic r, input logic rv, input logic [15:0] rp,
                               input logic rd, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; redirect_valid = rv; redirect_pc = rp; id_ready = rd;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 16'h1000);
`ifdef IFETCH_HALT_EN
    mem[16'h0003] = 16'hF123;
`endif
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b1;

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 2);
    // Boot, then 0x10, 0x11, 0x12 streaming out.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2);
    // Redirects, one with decode stalled.
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3);
    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 5);
`ifdef IFETCH_HALT_EN
    applyStimulus(1'b0, 1'b1, 16'h0001, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3);
`endif
    // Random traffic, restricted to low addresses so wrap and halt regions stay rare.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 16'h3FFF)),
                    ($urandom_range(0, 2) != 0), 1);
    end
    // Reset mid-stall, together with a redirect.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 16'h0077, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 4);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 16-bit RISC pipeline. Holds the program counter, drives the word address of the combinational instruction memory, and registers the returned 16-bit instruction into the IF/ID pipeline register with a valid/ready handshake toward decode. Accepts branch/jump redirects from downstream, flushing the in-flight instruction.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode in instr[15:12] that halts fetch (used only when IFETCH_HALT_EN is defined).

Ports:
- clk  in  1  single clock for the whole block; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  16  word address to instruction memory; always equals the PC register.
- imem_data  in  16  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  take a branch/jump this cycle.
- redirect_pc  in  16  target word address, sampled when redirect_valid=1.
- id_ready  in  1  decode accepts the IF/ID contents this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  16  registered instruction.
- id_pc  out  16  address the instruction was fetched from.
- id_pc_plus1  out  16  id_pc+1 (mod 2^16), registered.
- halted  out  1  fetch stopped on a halt instruction; constant 0 without IFETCH_HALT_EN.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT; BOOT -> RUN unconditionally next cycle, no load in BOOT.
- Reset values: pc=RESET_PC, id_valid=0, id_instr=16'h0000, id_pc=16'h0000, id_pc_plus1=16'h0000, halted=0.
- RUN, priority per cycle:
  - redirect_valid=1: pc<=redirect_pc, id_valid<=0 (flush), ignoring id_ready and imem_data.
  - else if id_valid=0 or id_ready=1: id_valid<=1, id_instr<=imem_data, id_pc<=pc, id_pc_plus1<=pc+1, pc<=pc+1.
  - else (stall): all registers hold.
- PC arithmetic: 16-bit unsigned, word-addressed, 16'hFFFF+1 wraps to 16'h0000; no carry out.
- HALT (macro only): see Configuration. In HALT no loads occur; id_valid clears when id_ready=1; redirect_valid=1 sets pc<=redirect_pc, halted<=0, id_valid<=0, state RUN.
- rst=1 overrides everything in any state, including mid-stall or same-cycle redirect.

## Timing
- imem_addr is combinational from the PC register; zero cycles from PC to address.
- Fetch latency: instruction at address A appears on id_instr the cycle after pc==A is loaded.
- First valid instruction after reset release: id_valid=1 two cycles after the last rst=1 cycle (BOOT, then first load).
- Redirect at cycle N: id_valid=0 at N+1, target instruction valid at N+2 (one-bubble penalty).
- Throughput: one instruction per cycle while id_ready=1 and no redirect.
- Handshake: id_instr/id_pc stable while id_valid=1 and id_ready=0.

## Configuration
- IFETCH_HALT_EN defined: when a load captures an instruction with imem_data[15:12]==HALT_OPCODE, the instruction is still passed to decode, pc is not incremented, halted<=1, state -> HALT.
- Not defined: no opcode inspection, HALT state unreachable, halted tied 0.

## Structure
- Package ifetch_pkg: state enum (BOOT, RUN, HALT), HALT_OPCODE default, NOP constant 16'h0000, address/instruction width constants (16).
- One sub-module: if_id_reg (IF/ID pipeline register with load, flush, hold, synchronous reset); FSM and PC live in instruction_fetch.

## Test plan
- Reset with RESET_PC=16'h0010, memory[i]=i+16'h1000, id_ready=1 -> imem_addr=0x0010 during reset; id_valid=1, id_instr=0x1010, id_pc=0x0010 two cycles after release; then 0x1011, 0x1012 on consecutive cycles.
- id_ready=0 for 3 cycles while id_valid=1 at id_pc=0x0012 -> id_instr, id_pc, imem_addr hold; resumes at 0x0013 after id_ready=1.
- Redirect to 0x0040 at cycle N (also with id_ready=0) -> id_valid=0 at N+1, id_pc=0x0040 valid at N+2.
- PC at 0xFFFF, continuous accept -> id_pc=0xFFFF, id_pc_plus1=0x0000, next id_pc=0x0000.
- IFETCH_HALT_EN, memory[0x0003]=16'hF123 -> id_instr=0xF123 delivered, halted=1, imem_addr stays 0x0003, no further valid; redirect to 0x0008 -> halted=0, id_pc=0x0008 two cycles later.
- rst=1 asserted mid-stall together with redirect_valid=1 -> next cycle all outputs at reset values, pc=RESET_PC.
